// File: rtl/eth_regs_pkg.sv
// Shared constants for the Ethernet AXI4-Lite register block: register
// selects, field bit positions and AXI response codes.
package eth_regs_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ADDR_LSB  = 2;
    localparam int REG_SEL_W = 3;

    // Register select = byte offset >> ADDR_LSB
    typedef enum logic [2:0] {
        SEL_CTRL       = 3'd0,
        SEL_MDIO_CMD   = 3'd1,
        SEL_MDIO_WDATA = 3'd2,
        SEL_MDIO_STAT  = 3'd3,
        SEL_CRC_CNT    = 3'd4,
        SEL_SCRATCH    = 3'd5,
        SEL_UNMAPPED_6 = 3'd6,
        SEL_UNMAPPED_7 = 3'd7
    } reg_sel_e;

    // Byte offsets, for software-facing documentation and benches
    localparam logic [7:0] OFF_CTRL       = 8'h00;
    localparam logic [7:0] OFF_MDIO_CMD   = 8'h04;
    localparam logic [7:0] OFF_MDIO_WDATA = 8'h08;
    localparam logic [7:0] OFF_MDIO_STAT  = 8'h0C;
    localparam logic [7:0] OFF_CRC_CNT    = 8'h10;
    localparam logic [7:0] OFF_SCRATCH    = 8'h14;

    // Field positions
    localparam int CTRL_TX_TEST_EN_BIT = 0;
    localparam int CMD_START_BIT       = 0;
    localparam int CMD_OP_BIT          = 1;
    localparam int CMD_PHY_LSB         = 2;
    localparam int CMD_REG_LSB         = 7;
    localparam int MDIO_ADDR_W         = 5;
    localparam int MDIO_DATA_W         = 16;
    localparam int STAT_BUSY_BIT       = 16;

    localparam logic [31:0] CRC_MAX = 32'hFFFF_FFFF;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Offsets 0x18 and 0x1C have no register behind them
    function automatic logic sel_is_mapped(input logic [2:0] sel);
        return (sel <= 3'd5);
    endfunction

endpackage

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite slave handshake: independent AW/W holding registers, B and R
// channel valid management. Presents a single-cycle write/read strobe to
// the register core.
module axi_lite_slave_if
    import eth_regs_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ADDR_LSB  = 2,
    parameter int REG_SEL_W = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 awvalid_i,
    output logic                 awready_o,
    input  logic [ADDR_W-1:0]    awaddr_i,
    input  logic                 wvalid_i,
    output logic                 wready_o,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic                 bvalid_o,
    output logic [1:0]           bresp_o,
    input  logic                 bready_i,
    input  logic                 arvalid_i,
    output logic                 arready_o,
    input  logic [ADDR_W-1:0]    araddr_i,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic [DATA_W-1:0]    rdata_o,
    output logic [1:0]           rresp_o,
    output logic                 wr_en_o,
    output logic [REG_SEL_W-1:0] wr_sel_o,
    output logic [DATA_W-1:0]    wr_data_o,
    output logic                 rd_en_o,
    output logic [REG_SEL_W-1:0] rd_sel_o,
    input  logic [DATA_W-1:0]    rd_data_i,
    input  logic                 rd_err_i,
    input  logic                 wr_err_i
);

    logic                 aw_held_q, aw_held_d;
    logic [REG_SEL_W-1:0] aw_sel_q,  aw_sel_d;
    logic                 w_held_q,  w_held_d;
    logic [DATA_W-1:0]    w_data_q,  w_data_d;
    logic                 bvalid_q,  bvalid_d;
    logic [1:0]           bresp_q,   bresp_d;
    logic                 rvalid_q,  rvalid_d;
    logic [DATA_W-1:0]    rdata_q,   rdata_d;
    logic [1:0]           rresp_q,   rresp_d;

    logic                 aw_hs_s, w_hs_s, commit_s;
    logic [REG_SEL_W-1:0] aw_sel_in_s;
    logic                 unused_s;

    // Only the register-select bits of the addresses take part in decode
    assign unused_s = ^{1'b0,
                        awaddr_i[ADDR_W-1:ADDR_LSB+REG_SEL_W], awaddr_i[ADDR_LSB-1:0],
                        araddr_i[ADDR_W-1:ADDR_LSB+REG_SEL_W], araddr_i[ADDR_LSB-1:0]};

    assign aw_sel_in_s = awaddr_i[ADDR_LSB +: REG_SEL_W];

    // Readies derive purely from state, so no new AW/W enters while a response is pending
    assign awready_o = ~aw_held_q & ~bvalid_q;
    assign wready_o  = ~w_held_q  & ~bvalid_q;
    assign arready_o = ~rvalid_q;

    assign aw_hs_s  = awvalid_i & awready_o;
    assign w_hs_s   = wvalid_i  & wready_o;
    assign commit_s = (aw_held_q | aw_hs_s) & (w_held_q | w_hs_s);

    assign wr_en_o   = commit_s;
    assign wr_sel_o  = aw_held_q ? aw_sel_q : aw_sel_in_s;
    assign wr_data_o = w_held_q  ? w_data_q : wdata_i;

    assign rd_en_o  = arvalid_i & arready_o;
    assign rd_sel_o = araddr_i[ADDR_LSB +: REG_SEL_W];

    assign bvalid_o = bvalid_q;
    assign bresp_o  = bresp_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign rresp_o  = rresp_q;

    // Write channel next state: hold AW/W until both present, then raise B
    always_comb begin
        aw_held_d = aw_held_q;
        aw_sel_d  = aw_sel_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (commit_s) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_err_i ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (aw_hs_s) begin
                aw_held_d = 1'b1;
                aw_sel_d  = aw_sel_in_s;
            end else begin
                aw_held_d = aw_held_q;
            end
            if (w_hs_s) begin
                w_held_d = 1'b1;
                w_data_d = wdata_i;
            end else begin
                w_held_d = w_held_q;
            end
            if (bvalid_q && bready_i) begin
                bvalid_d = 1'b0;
            end else begin
                bvalid_d = bvalid_q;
            end
        end
    end

    // Read channel next state: register data on accept, hold until rready
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rd_en_o) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data_i;
            rresp_d  = rd_err_i ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && rready_i) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // Handshake state registers; reset drops every valid and holding register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_held_q <= 1'b0;
            aw_sel_q  <= {REG_SEL_W{1'b0}};
            w_held_q  <= 1'b0;
            w_data_q  <= {DATA_W{1'b0}};
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_W{1'b0}};
            rresp_q   <= 2'b00;
        end else begin
            aw_held_q <= aw_held_d;
            aw_sel_q  <= aw_sel_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: rtl/eth_axi_regs.sv
// Ethernet control/status register file behind an AXI4-Lite slave:
// TX test enable, MDIO command/data/status and a saturating good-CRC counter.
module eth_axi_regs
    import eth_regs_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ADDR_LSB  = 2,
    parameter int REG_SEL_W = 3
) (
    input  logic              AXI_Clk,
    input  logic              AXI_Rstn,
    input  logic              AXI_awvalid,
    output logic              AXI_awready,
    input  logic [ADDR_W-1:0] AXI_awaddr,
    input  logic              AXI_wvalid,
    output logic              AXI_wready,
    input  logic [DATA_W-1:0] AXI_wdata,
    output logic              AXI_bvalid,
    output logic [1:0]        AXI_bresp,
    input  logic              AXI_bready,
    input  logic              AXI_arvalid,
    output logic              AXI_arready,
    input  logic [ADDR_W-1:0] AXI_araddr,
    output logic              AXI_rvalid,
    input  logic              AXI_rready,
    output logic [DATA_W-1:0] AXI_rdata,
    output logic [1:0]        AXI_rresp,
    input  logic              Crc_Ok_Pulse,
    input  logic              Mdio_Busy,
    input  logic              Mdio_Done,
    input  logic [15:0]       Mdio_Rdata,
    output logic              Tx_Test_En,
    output logic              Mdio_Start,
    output logic              Mdio_Op,
    output logic [4:0]        Mdio_Phy_Addr,
    output logic [4:0]        Mdio_Reg_Addr,
    output logic [15:0]       Mdio_Wdata
);

    logic                 wr_en_s, rd_en_s, wr_err_s, rd_err_s;
    logic [REG_SEL_W-1:0] wr_sel_s, rd_sel_s;
    logic [DATA_W-1:0]    wr_data_s, rd_data_s;
    reg_sel_e             wr_sel_e_s, rd_sel_e_s;

    logic        tx_test_en_q, tx_test_en_d;
    logic        mdio_start_q, mdio_start_d;
    logic        mdio_op_q,    mdio_op_d;
    logic [4:0]  mdio_phy_q,   mdio_phy_d;
    logic [4:0]  mdio_reg_q,   mdio_reg_d;
    logic [15:0] mdio_wdata_q, mdio_wdata_d;
    logic [15:0] mdio_stat_q,  mdio_stat_d;
    logic [31:0] crc_cnt_q,    crc_cnt_d;
    logic [31:0] scratch_q,    scratch_d;
    logic        unused_s;

    axi_lite_slave_if #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ADDR_LSB  (ADDR_LSB),
        .REG_SEL_W (REG_SEL_W)
    ) u_if (
        .clk_i     (AXI_Clk),
        .rst_ni    (AXI_Rstn),
        .awvalid_i (AXI_awvalid),
        .awready_o (AXI_awready),
        .awaddr_i  (AXI_awaddr),
        .wvalid_i  (AXI_wvalid),
        .wready_o  (AXI_wready),
        .wdata_i   (AXI_wdata),
        .bvalid_o  (AXI_bvalid),
        .bresp_o   (AXI_bresp),
        .bready_i  (AXI_bready),
        .arvalid_i (AXI_arvalid),
        .arready_o (AXI_arready),
        .araddr_i  (AXI_araddr),
        .rvalid_o  (AXI_rvalid),
        .rready_i  (AXI_rready),
        .rdata_o   (AXI_rdata),
        .rresp_o   (AXI_rresp),
        .wr_en_o   (wr_en_s),
        .wr_sel_o  (wr_sel_s),
        .wr_data_o (wr_data_s),
        .rd_en_o   (rd_en_s),
        .rd_sel_o  (rd_sel_s),
        .rd_data_i (rd_data_s),
        .rd_err_i  (rd_err_s),
        .wr_err_i  (wr_err_s)
    );

    // The read mux is always live; the strobe only matters inside the interface
    assign unused_s   = ^{1'b0, rd_en_s};
    assign wr_sel_e_s = reg_sel_e'(wr_sel_s);
    assign rd_sel_e_s = reg_sel_e'(rd_sel_s);
    assign wr_err_s   = ~sel_is_mapped(wr_sel_s);
    assign rd_err_s   = ~sel_is_mapped(rd_sel_s);

    assign Tx_Test_En    = tx_test_en_q;
    assign Mdio_Start    = mdio_start_q;
    assign Mdio_Op       = mdio_op_q;
    assign Mdio_Phy_Addr = mdio_phy_q;
    assign Mdio_Reg_Addr = mdio_reg_q;
    assign Mdio_Wdata    = mdio_wdata_q;

    // Read mux; pre-update register values, so a same-cycle increment is not visible
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        case (rd_sel_e_s)
            SEL_CTRL:       rd_data_s[CTRL_TX_TEST_EN_BIT] = tx_test_en_q;
            SEL_MDIO_CMD: begin
                rd_data_s[CMD_OP_BIT]                  = mdio_op_q;
                rd_data_s[CMD_PHY_LSB +: MDIO_ADDR_W]  = mdio_phy_q;
                rd_data_s[CMD_REG_LSB +: MDIO_ADDR_W]  = mdio_reg_q;
            end
            SEL_MDIO_WDATA: rd_data_s[MDIO_DATA_W-1:0] = mdio_wdata_q;
            SEL_MDIO_STAT: begin
                rd_data_s[MDIO_DATA_W-1:0] = mdio_stat_q;
                rd_data_s[STAT_BUSY_BIT]   = Mdio_Busy;
            end
            SEL_CRC_CNT:    rd_data_s = crc_cnt_q;
            SEL_SCRATCH:    rd_data_s = scratch_q;
            default:        rd_data_s = {DATA_W{1'b0}};
        endcase
    end

    // Software-written registers and the MDIO start strobe
    always_comb begin
        tx_test_en_d = tx_test_en_q;
        mdio_start_d = 1'b0;
        mdio_op_d    = mdio_op_q;
        mdio_phy_d   = mdio_phy_q;
        mdio_reg_d   = mdio_reg_q;
        mdio_wdata_d = mdio_wdata_q;
        scratch_d    = scratch_q;
        if (wr_en_s) begin
            case (wr_sel_e_s)
                SEL_CTRL:       tx_test_en_d = wr_data_s[CTRL_TX_TEST_EN_BIT];
                SEL_MDIO_CMD: begin
                    mdio_op_d    = wr_data_s[CMD_OP_BIT];
                    mdio_phy_d   = wr_data_s[CMD_PHY_LSB +: MDIO_ADDR_W];
                    mdio_reg_d   = wr_data_s[CMD_REG_LSB +: MDIO_ADDR_W];
                    // A start request while the controller is busy is dropped
                    mdio_start_d = wr_data_s[CMD_START_BIT] & ~Mdio_Busy;
                end
                SEL_MDIO_WDATA: mdio_wdata_d = wr_data_s[MDIO_DATA_W-1:0];
                SEL_SCRATCH:    scratch_d    = wr_data_s;
                default:        mdio_start_d = 1'b0;
            endcase
        end else begin
            mdio_start_d = 1'b0;
        end
    end

    // Status capture: MDIO read data on done, saturating CRC counter with clear priority
    always_comb begin
        if (Mdio_Done) begin
            mdio_stat_d = Mdio_Rdata;
        end else begin
            mdio_stat_d = mdio_stat_q;
        end
        if (wr_en_s && (wr_sel_e_s == SEL_CRC_CNT)) begin
            crc_cnt_d = 32'h0000_0000;
        end else if (Crc_Ok_Pulse && (crc_cnt_q != CRC_MAX)) begin
            crc_cnt_d = crc_cnt_q + 32'd1;
        end else begin
            crc_cnt_d = crc_cnt_q;
        end
    end

    // Register core state; all outputs are driven straight from these flops
    always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
        if (!AXI_Rstn) begin
            tx_test_en_q <= 1'b0;
            mdio_start_q <= 1'b0;
            mdio_op_q    <= 1'b0;
            mdio_phy_q   <= 5'd0;
            mdio_reg_q   <= 5'd0;
            mdio_wdata_q <= 16'h0000;
            mdio_stat_q  <= 16'h0000;
            crc_cnt_q    <= 32'h0000_0000;
            scratch_q    <= 32'h0000_0000;
        end else begin
            tx_test_en_q <= tx_test_en_d;
            mdio_start_q <= mdio_start_d;
            mdio_op_q    <= mdio_op_d;
            mdio_phy_q   <= mdio_phy_d;
            mdio_reg_q   <= mdio_reg_d;
            mdio_wdata_q <= mdio_wdata_d;
            mdio_stat_q  <= mdio_stat_d;
            crc_cnt_q    <= crc_cnt_d;
            scratch_q    <= scratch_d;
        end
    end

endmodule

// File: tb/tb_eth_axi_regs.sv
// Self-checking bench for eth_axi_regs: directed vector table, hand-written
// handshake corner cases and a randomized run against a register-map model.
module tb_eth_axi_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [1:0]  bresp, rresp;
    logic        crc_pulse, mdio_busy, mdio_done, tx_en, mdio_start, mdio_op;
    logic [15:0] mdio_rdata, mdio_wdata;
    logic [4:0]  mdio_phy, mdio_reg;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    eth_axi_regs dut (
        .AXI_Clk(clk), .AXI_Rstn(rst_n),
        .AXI_awvalid(awvalid), .AXI_awready(awready), .AXI_awaddr(awaddr),
        .AXI_wvalid(wvalid), .AXI_wready(wready), .AXI_wdata(wdata),
        .AXI_bvalid(bvalid), .AXI_bresp(bresp), .AXI_bready(bready),
        .AXI_arvalid(arvalid), .AXI_arready(arready), .AXI_araddr(araddr),
        .AXI_rvalid(rvalid), .AXI_rready(rready), .AXI_rdata(rdata), .AXI_rresp(rresp),
        .Crc_Ok_Pulse(crc_pulse), .Mdio_Busy(mdio_busy), .Mdio_Done(mdio_done),
        .Mdio_Rdata(mdio_rdata), .Tx_Test_En(tx_en), .Mdio_Start(mdio_start),
        .Mdio_Op(mdio_op), .Mdio_Phy_Addr(mdio_phy), .Mdio_Reg_Addr(mdio_reg),
        .Mdio_Wdata(mdio_wdata)
    );

    // Count cycles with Mdio_Start high: one request must add exactly one
    always @(negedge clk) if (mdio_start === 1'b1) start_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             output logic [1:0] resp, output int lat);
        bit aw_d, w_d;
        aw_d = 1'b0; w_d = 1'b0; resp = 2'bxx; lat = -1;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 40 && !(aw_d && w_d); i++) begin
            @(negedge clk);
            if (awvalid && awready) aw_d = 1'b1;
            if (wvalid && wready)   w_d  = 1'b1;
            @(posedge clk); #1;
            if (aw_d) awvalid = 1'b0;
            if (w_d)  wvalid  = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_d && w_d)) begin
            timeout_fail("wr_accept");
            return;
        end
        bready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bvalid) begin resp = bresp; lat = i; break; end
        end
        @(posedge clk); #1;
        bready = 1'b0;
        if (lat < 0) timeout_fail("wr_bvalid");
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        bit ar_d;
        ar_d = 1'b0; data = 32'hxxxx_xxxx; resp = 2'bxx; lat = -1;
        araddr = addr; arvalid = 1'b1;
        for (int i = 0; i < 40 && !ar_d; i++) begin
            @(negedge clk);
            if (arready) ar_d = 1'b1;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        if (!ar_d) begin
            timeout_fail("rd_accept");
            return;
        end
        rready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rvalid) begin data = rdata; resp = rresp; lat = i; break; end
        end
        @(posedge clk); #1;
        rready = 1'b0;
        if (lat < 0) timeout_fail("rd_rvalid");
    endtask

    task automatic crc_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            crc_pulse = 1'b1;
            @(posedge clk); #1;
            crc_pulse = 1'b0;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic [1:0]  resp;
    } vec_t;

    vec_t        tbl [13];
    logic [31:0] mreg [8];
    logic [15:0] m_stat;
    logic [31:0] rd, exp_rd;
    logic [1:0]  rsp;
    int          lat, s0, op, n;
    logic [2:0]  sel;
    logic [31:0] d;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        {awvalid, wvalid, bready, arvalid, rready} = 5'b0;
        awaddr = 32'h0; wdata = 32'h0; araddr = 32'h0;
        crc_pulse = 1'b0; mdio_busy = 1'b0; mdio_done = 1'b0; mdio_rdata = 16'h0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_outputs", {tx_en, mdio_start, mdio_op, mdio_phy, mdio_reg, mdio_wdata}, 32'd0);
        check("rst_readies", {29'd0, awready, wready, arready}, 32'd7);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- directed vector table ----
        tbl[0]  = '{1'b1, 32'h14, 32'hA5A5_1234, 32'h0,         2'b00};
        tbl[1]  = '{1'b0, 32'h14, 32'h0,         32'hA5A5_1234, 2'b00};
        tbl[2]  = '{1'b0, 32'h18, 32'h0,         32'h0,         2'b10};
        tbl[3]  = '{1'b1, 32'h1C, 32'hFFFF_FFFF, 32'h0,         2'b10};
        tbl[4]  = '{1'b0, 32'h14, 32'h0,         32'hA5A5_1234, 2'b00};
        tbl[5]  = '{1'b0, 32'h00, 32'h0,         32'h0,         2'b00};
        tbl[6]  = '{1'b1, 32'h08, 32'h1234_BEEF, 32'h0,         2'b00};
        tbl[7]  = '{1'b0, 32'h08, 32'h0,         32'h0000_BEEF, 2'b00};
        tbl[8]  = '{1'b1, 32'h0C, 32'hFFFF_FFFF, 32'h0,         2'b00};
        tbl[9]  = '{1'b0, 32'h0C, 32'h0,         32'h0,         2'b00};
        tbl[10] = '{1'b0, 32'h1C, 32'h0,         32'h0,         2'b10};
        tbl[11] = '{1'b1, 32'h18, 32'h0000_0001, 32'h0,         2'b10};
        tbl[12] = '{1'b0, 32'h04, 32'h0,         32'h0,         2'b00};
        s0 = start_cnt;
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, rsp, lat);
                check($sformatf("vec%0d_bresp", i), {30'd0, rsp}, {30'd0, tbl[i].resp});
                check($sformatf("vec%0d_blat", i), lat, 32'd0);
            end else begin
                axi_read(tbl[i].addr, rd, rsp, lat);
                check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
                check($sformatf("vec%0d_rresp", i), {30'd0, rsp}, {30'd0, tbl[i].resp});
                check($sformatf("vec%0d_rlat", i), lat, 32'd0);
            end
        end
        check("vec_no_start", start_cnt - s0, 32'd0);
        check("vec_mdio_wdata_out", {16'd0, mdio_wdata}, 32'h0000_BEEF);
        check("vec_tx_unchanged", {31'd0, tx_en}, 32'd0);

        // ---- W two cycles ahead of AW, then bready held low ----
        wdata = 32'h1; wvalid = 1'b1;
        @(negedge clk);
        check("wfirst_wready", {31'd0, wready}, 32'd1);
        @(posedge clk); #1; wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("wfirst_no_bvalid", {31'd0, bvalid}, 32'd0);
            check("wfirst_readies", {30'd0, awready, wready}, 32'd2);
            @(posedge clk); #1;
        end
        awaddr = 32'h0; awvalid = 1'b1;
        @(negedge clk);
        check("wfirst_awready", {31'd0, awready}, 32'd1);
        @(posedge clk); #1; awvalid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bstall_bvalid", {31'd0, bvalid}, 32'd1);
            check("bstall_readies", {30'd0, awready, wready}, 32'd0);
            check("bstall_tx_en", {31'd0, tx_en}, 32'd1);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1; bready = 1'b0;
        @(negedge clk);
        check("bstall_released", {30'd0, bvalid, awready}, 32'd1);
        @(posedge clk); #1;

        // ---- MDIO start strobe ----
        mdio_busy = 1'b0; s0 = start_cnt;
        axi_write(32'h04, 32'h0000_0D0B, rsp, lat);
        check("mdio_start_once", start_cnt - s0, 32'd1);
        check("mdio_fields", {21'd0, mdio_reg, mdio_phy, mdio_op}, {21'd0, 5'd26, 5'd2, 1'b1});
        axi_read(32'h04, rd, rsp, lat);
        check("mdio_cmd_readback", rd, 32'h0000_0D0A);
        mdio_busy = 1'b1; s0 = start_cnt;
        axi_write(32'h04, 32'h0000_0F85, rsp, lat);
        check("mdio_busy_bresp", {30'd0, rsp}, 32'd0);
        check("mdio_busy_no_start", start_cnt - s0, 32'd0);
        check("mdio_busy_fields", {21'd0, mdio_reg, mdio_phy, mdio_op}, {21'd0, 5'd31, 5'd1, 1'b0});
        mdio_rdata = 16'h1234; mdio_done = 1'b1;
        @(posedge clk); #1;
        mdio_done = 1'b0; mdio_rdata = 16'hFFFF;
        axi_read(32'h0C, rd, rsp, lat);
        check("mdio_stat", rd, 32'h0001_1234);
        mdio_busy = 1'b0;

        // ---- CRC counter ----
        axi_write(32'h10, 32'h0, rsp, lat);
        crc_pulses(3);
        axi_read(32'h10, rd, rsp, lat);
        check("crc_three", rd, 32'd3);
        awaddr = 32'h10; wdata = 32'h0; awvalid = 1'b1; wvalid = 1'b1; crc_pulse = 1'b1;
        @(negedge clk);
        check("crc_clr_readies", {30'd0, awready, wready}, 32'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; crc_pulse = 1'b0; bready = 1'b1;
        @(negedge clk);
        check("crc_clr_bvalid", {31'd0, bvalid}, 32'd1);
        @(posedge clk); #1; bready = 1'b0;
        axi_read(32'h10, rd, rsp, lat);
        check("crc_clear_wins", rd, 32'd0);
        crc_pulses(1);
        araddr = 32'h10; arvalid = 1'b1; crc_pulse = 1'b1;
        @(negedge clk);
        check("crc_rd_arready", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0; crc_pulse = 1'b0; rready = 1'b1;
        @(negedge clk);
        check("crc_rd_pre_incr", rd === 32'hx ? 32'hx : rdata, 32'd1);
        @(posedge clk); #1; rready = 1'b0;
        axi_read(32'h10, rd, rsp, lat);
        check("crc_post_incr", rd, 32'd2);

        // ---- randomized run against the register-map model ----
        axi_write(32'h00, 32'h0, rsp, lat);
        axi_write(32'h04, 32'h0, rsp, lat);
        axi_write(32'h08, 32'h0, rsp, lat);
        axi_write(32'h10, 32'h0, rsp, lat);
        axi_write(32'h14, 32'h0, rsp, lat);
        for (int i = 0; i < 8; i++) mreg[i] = 32'h0;
        m_stat = 16'h1234;
        for (int it = 0; it < 160; it++) begin
            mdio_busy = 1'($urandom_range(0, 1));
            op  = $urandom_range(0, 3);
            sel = 3'($urandom_range(0, 7));
            d   = $urandom;
            case (op)
                0: begin
                    s0 = start_cnt;
                    axi_write({27'd0, sel, 2'($urandom_range(0, 3))}, d, rsp, lat);
                    check($sformatf("rnd%0d_bresp", it), {30'd0, rsp}, (sel >= 3'd6) ? 32'd2 : 32'd0);
                    check($sformatf("rnd%0d_start", it), start_cnt - s0,
                          (sel == 3'd1 && d[0] && !mdio_busy) ? 32'd1 : 32'd0);
                    case (sel)
                        3'd0: mreg[0] = {31'd0, d[0]};
                        3'd1: mreg[1] = d & 32'h0000_0FFE;
                        3'd2: mreg[2] = d & 32'h0000_FFFF;
                        3'd4: mreg[4] = 32'h0;
                        3'd5: mreg[5] = d;
                        default: ;
                    endcase
                end
                1: begin
                    axi_read({27'd0, sel, 2'b00}, rd, rsp, lat);
                    if (sel == 3'd3)      exp_rd = {15'd0, mdio_busy, m_stat};
                    else if (sel >= 3'd6) exp_rd = 32'h0;
                    else                  exp_rd = mreg[sel];
                    check($sformatf("rnd%0d_rdata_sel%0d", it, sel), rd, exp_rd);
                    check($sformatf("rnd%0d_rresp", it), {30'd0, rsp}, (sel >= 3'd6) ? 32'd2 : 32'd0);
                end
                2: begin
                    n = $urandom_range(1, 4);
                    crc_pulses(n);
                    mreg[4] = mreg[4] + 32'(n);
                end
                default: begin
                    m_stat = 16'($urandom);
                    mdio_rdata = m_stat; mdio_done = 1'b1;
                    @(posedge clk); #1;
                    mdio_done = 1'b0; mdio_rdata = 16'($urandom);
                end
            endcase
            check($sformatf("rnd%0d_outs", it),
                  {15'd0, tx_en, mdio_reg, mdio_phy, mdio_op, 5'd0},
                  {15'd0, mreg[0][0], mreg[1][11:1], 5'd0});
            check($sformatf("rnd%0d_wdata_out", it), {16'd0, mdio_wdata}, {16'd0, mreg[2][15:0]});
        end
        mdio_busy = 1'b0;

        // ---- saturation: start the counter one below the ceiling ----
        force dut.crc_cnt_q = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release dut.crc_cnt_q;
        crc_pulses(1);
        axi_read(32'h10, rd, rsp, lat);
        check("crc_reach_max", rd, 32'hFFFF_FFFF);
        crc_pulses(2);
        axi_read(32'h10, rd, rsp, lat);
        check("crc_saturate", rd, 32'hFFFF_FFFF);

        // ---- asynchronous reset with B and R responses pending ----
        axi_write(32'h00, 32'h1, rsp, lat);
        awaddr = 32'h14; wdata = 32'h5555_AAAA; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h14; arvalid = 1'b1;
        @(posedge clk); #1; arvalid = 1'b0;
        @(negedge clk);
        check("prerst_valids", {30'd0, bvalid, rvalid}, 32'd3);
        check("prerst_tx_en", {31'd0, tx_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valids", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_async_tx_en", {31'd0, tx_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read(32'h10, rd, rsp, lat);
        check("rst_crc_cleared", rd, 32'd0);
        axi_read(32'h14, rd, rsp, lat);
        check("rst_scratch_cleared", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_axi_regs.md
Name: eth_axi_regs

Overview:
- AXI4-Lite slave register file in the AXI_Clk domain.
- Sits directly downstream of the PS M_AXI_0 master and is instantiated inside eth_top.
- Exposes control, MDIO command/data and CRC statistics to software; drives the MDIO controller and TX test logic.
- All status inputs arrive already synchronised to AXI_Clk (CDC is handled in eth_top).

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width; fixed at 32
- ADDR_LSB, 2, byte-offset bits ignored in decode
- REG_SEL_W, 3, register-select bits, addr[ADDR_LSB+2:ADDR_LSB]

Ports:
- AXI_Clk in 1: single clock.
- AXI_Rstn in 1: asynchronous, active-low reset.
- AXI_awvalid in 1, AXI_awready out 1, AXI_awaddr in ADDR_W: write address channel.
- AXI_wvalid in 1, AXI_wready out 1, AXI_wdata in DATA_W: write data channel. No wstrb; all writes are full-word.
- AXI_bvalid out 1, AXI_bresp out 2, AXI_bready in 1: write response channel.
- AXI_arvalid in 1, AXI_arready out 1, AXI_araddr in ADDR_W: read address channel.
- AXI_rvalid out 1, AXI_rready in 1, AXI_rdata out DATA_W, AXI_rresp out 2: read data channel.
- Crc_Ok_Pulse in 1: one-cycle pulse per good received frame.
- Mdio_Busy in 1, Mdio_Done in 1, Mdio_Rdata in 16: MDIO controller status.
- Tx_Test_En out 1: enables the TX test pattern.
- Mdio_Start out 1: one-cycle MDIO transaction request.
- Mdio_Op out 1: 1 = read, 0 = write.
- Mdio_Phy_Addr out 5, Mdio_Reg_Addr out 5, Mdio_Wdata out 16: MDIO command fields.

Behaviour:
- Reset: all outputs 0, all registers 0, all channel handshakes idle.
- Register map (offset, access):
  - 0x00 CTRL, RW: [0] Tx_Test_En.
  - 0x04 MDIO_CMD, RW: [0] start (write-only strobe, reads 0), [1] op, [6:2] phy, [11:7] reg.
  - 0x08 MDIO_WDATA, RW: [15:0].
  - 0x0C MDIO_STAT, RO: [15:0] last read data, [16] busy.
  - 0x10 CRC_CNT, RO; any write clears it.
  - 0x14 SCRATCH, RW, 32-bit.
  - 0x18–0x1C: unmapped.
- Write path:
  - AW and W are captured independently into holding registers. awready is high when no address is held and bvalid=0; wready likewise for data.
  - Commit occurs on the cycle both are held, or both handshake in the same cycle. Registers update and bvalid rises the next edge.
  - AW+W accepted at T gives register update and bvalid=1 at T+1. bvalid holds until bready.
  - No new AW/W is accepted while bvalid=1.
  - bresp: 00 for mapped offsets; 10 (SLVERR) for unmapped, with no side effect. Writes to MDIO_STAT respond 00 and are ignored.
- Read path:
  - arready = ~rvalid.
  - arvalid&arready at T gives rdata/rresp registered and rvalid=1 at T+1. rdata is held stable until rready.
  - Unmapped reads return rdata=0, rresp=10.
- MDIO:
  - A write to MDIO_CMD latches op/phy/reg.
  - If wdata[0]=1 and Mdio_Busy=0, Mdio_Start pulses for exactly 1 cycle (same edge as the register update).
  - If busy, the start is dropped; the fields still update and bresp=00.
  - Mdio_Done captures Mdio_Rdata into MDIO_STAT[15:0].
- CRC_CNT:
  - Increments on Crc_Ok_Pulse and saturates at 0xFFFFFFFF.
  - Clear and pulse in the same cycle: clear wins, result 0.
  - A read in the same cycle as an increment returns the pre-increment value.
- Reset mid-transaction: all valids drop immediately and holding registers clear. The master must reissue.

Decomposition:
- Package eth_regs_pkg holds register offsets, CTRL/MDIO_CMD field bit positions, RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- The AXI handshake (AW/W holding, B/R valid management) is split into sub-module axi_lite_slave_if. It presents wr_en/wr_sel/wr_data/rd_en/rd_sel to the register core, which returns rd_data/rd_err/wr_err.

Test Plan:
- AW+W same cycle to 0x14 with 0xA5A5_1234, then read 0x14 → bvalid at T+1 with bresp=00; rdata=0xA5A5_1234, rresp=00, rvalid at T+1 after AR.
- W two cycles before AW, write 0x1 to 0x00 → no bvalid until AW arrives; then Tx_Test_En=1 and bvalid next cycle; bready held low 5 cycles → bvalid and awready/wready stay stable (bvalid=1, readies=0).
- Write 0x0000_0D0B to 0x04 with Mdio_Busy=0 → Mdio_Start high exactly 1 cycle, Mdio_Op=1, Phy=2, Reg=26. Repeat with Mdio_Busy=1 → no pulse, bresp=00.
- 3 Crc_Ok_Pulses then read 0x10 → 3. Write 0x10 in the same cycle as a pulse → read returns 0. Preload 0xFFFFFFFF plus a pulse → stays 0xFFFFFFFF.
- Read 0x18 → rdata=0, rresp=10. Write 0x1C → bresp=10 and all registers unchanged.
- Assert AXI_Rstn low while rvalid=1 → rvalid, bvalid, Tx_Test_En and CRC_CNT all 0 asynchronously.
